// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch front end: PC generator, DEPTH-entry prefetch queue and
// a program-end state machine (FETCH -> DRAIN -> DONE).
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined   : perf_fetch_cnt counts pushes, perf_flush_cnt counts redirects
//   undefined : both counter ports are tied to zero
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr / imem_inst    combinational instruction memory read port
//   out_valid/out_ready      queue head handshake toward decode
//   out_pc / out_inst        head entry contents
//   redirect_*               taken-branch redirect from EX/MEM
//   done                     program finished, queue drained
//   perf_fetch_cnt/_flush_cnt performance counters (see macro above)
module fetch_unit #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int MEM_LEN = 32,
  parameter int DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_base,
  input  logic [ADDR_W-1:0] redirect_offset,
  input  logic              redirect_backward,
  output logic              done,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
);

  // The extra PC bit lets the end of the program (and a wrapped backward
  // target) be told apart from a real instruction address.
  localparam int PC_W  = ADDR_W + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PC_W-1:0]  END_PC   = PC_W'(MEM_LEN);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {FETCH, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   target;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [DATA_W-1:0] q_inst [DEPTH];
  logic              pop;
  logic              push;

  assign pc_inc = pc + PC_W'(1);

  // Backward underflow wraps in PC_W bits and therefore lands past MEM_LEN.
  assign target = redirect_backward ?
                  ({1'b0, redirect_base} - {1'b0, redirect_offset}) :
                  ({1'b0, redirect_base} + {1'b0, redirect_offset});

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full queue can still accept a word when the head leaves this cycle.
  assign push      = (state == FETCH) && !redirect_valid &&
                     ((count < FULL_CNT) || pop);

  assign imem_addr = pc[ADDR_W-1:0];
  assign out_pc    = q_pc[rd_ptr];
  assign out_inst  = q_inst[rd_ptr];
  assign done      = (state == DONE);

  // PC, pointers and occupancy; a redirect flushes everything and wins over
  // any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc_inc;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      q_pc[wr_ptr]   <= pc[ADDR_W-1:0];
      q_inst[wr_ptr] <= imem_inst;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = (target < END_PC) ? FETCH : DONE;
    end else begin
      case (state)
        FETCH:   if (push && (pc_inc == END_PC)) state_next = DRAIN;
        DRAIN:   if (pop && (count == CNT_W'(1))) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  // Free-running wrap-around counters for pushes and accepted redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (redirect_valid) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
